spi_datos_tx: RTL and testbench
===============================

SPI_DATOS_TX -- requirements
Module: spi_datos_tx

Interface
REQ-001 The block SHALL have parameter DIV, default 2, giving the SCLK half-period in clk cycles (legal range 1..255).
REQ-002 The block SHALL have parameter BITS, default 12, giving the frame length in bits (legal range 1..32).
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port start  input  1  frame request; sampled only in IDLE.
REQ-006 The block SHALL have port datos_in  input  32  data-register contents; only bits [BITS-1:0] used.
REQ-007 The block SHALL have port miso  input  1  serial data from slave.
REQ-008 The block SHALL have port sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-009 The block SHALL have port mosi  output  1  serial data to slave, MSB first.
REQ-010 The block SHALL have port cs_n  output  1  active-low slave select.
REQ-011 The block SHALL have port busy  output  1  high while a frame is in progress.
REQ-012 The block SHALL have port datos_rx  output  32  received word, {zero-fill, rx[BITS-1:0]}, feeds data-register IN2.
REQ-013 The block SHALL have port wr_rx  output  1  one-cycle write strobe for datos_rx, feeds data-register WR2.
REQ-014 The block SHALL have port done  output  1  one-cycle end-of-frame pulse, coincident with wr_rx.

Function
REQ-015 The FSM SHALL have states IDLE, LEAD, HIGH, LOW, TRAIL; every non-IDLE state SHALL last exactly DIV cycles, timed by a phase counter.
REQ-016 In IDLE, a clk edge with start=1 SHALL load tx shift register from datos_in[BITS-1:0], clear bit counter, set cs_n=0, busy=1, mosi=datos_in[BITS-1], and enter LEAD.
REQ-017 LEAD -> HIGH: the edge entering HIGH SHALL set sclk=1 and shift miso into the rx shift register LSB (sample on rising SCLK).
REQ-018 HIGH -> LOW if fewer than BITS bits sampled: the edge SHALL set sclk=0 and advance mosi to the next lower tx bit.
REQ-019 HIGH -> TRAIL after the BITS-th sample: sclk=0, mosi unchanged.
REQ-020 LOW -> HIGH: same actions as REQ-017.
REQ-021 TRAIL -> IDLE: the edge SHALL set cs_n=1, busy=0, mosi=0, datos_rx={zeros, rx}, and pulse done=1 and wr_rx=1 for exactly one cycle.
REQ-022 cs_n SHALL be low for exactly (2*BITS+1)*DIV cycles per frame; exactly BITS sclk rising edges SHALL occur per frame.
REQ-023 start while busy=1 SHALL be ignored, with no queuing.
REQ-024 start=1 in the done cycle SHALL be accepted, so cs_n is high for exactly one cycle between back-to-back frames.
REQ-025 datos_in SHALL be sampled only at the start edge; later changes SHALL not affect the frame in progress.
REQ-026 datos_rx SHALL hold its value between frames and change only on the wr_rx cycle.
REQ-027 datos_rx[31:BITS] SHALL always be 0.

Reset
REQ-028 While rst=1, at every edge, the block SHALL set state=IDLE, sclk=0, mosi=0, cs_n=1, busy=0, done=0, wr_rx=0, datos_rx=0, and clear counters and shift registers.
REQ-029 rst SHALL take priority over start.
REQ-030 rst mid-frame SHALL abort the frame immediately with no wr_rx or done pulse.

Verification
REQ-031 DIV=2, BITS=12, datos_in=0x00000A5C, miso looped to mosi, one start pulse -> mosi bits 1010_0101_1100; cs_n low 50 cycles; 12 sclk rises; wr_rx/done one cycle; datos_rx=0x00000A5C.
REQ-032 miso tied 1, datos_in=0xFFFFF000 -> mosi all 0 for 12 bits; datos_rx=0x00000FFF; upper datos_in bits are not transmitted.
REQ-033 start re-pulsed at cycles 5 and 30 of a frame -> ignored; exactly one frame, one wr_rx.
REQ-034 start held high continuously -> back-to-back frames; cs_n high exactly 1 cycle between frames; one wr_rx per frame.
REQ-035 rst asserted at cycle 20 of a frame -> next edge cs_n=1, sclk=0, busy=0, datos_rx=0, no wr_rx; a fresh start then completes a normal frame.
REQ-036 DIV=1, BITS=1, datos_in=0x1, miso=0 -> cs_n low 3 cycles; mosi=1 during the frame; datos_rx=0x0.

Source files
------------

// File: rtl/spi_datos_tx_if.sv
// Signal bundle for spi_datos_tx: host-side frame handshake, receive-word port and the four SPI pins.
// "slave" is the transmitter's view; "master" is the environment (host plus SPI device) that drives it.
interface spi_datos_tx_if;
   logic        start;
   logic [31:0] datos_in;
   logic        busy;
   logic [31:0] datos_rx;
   logic        wr_rx;
   logic        done;
   logic        sclk;
   logic        mosi;
   logic        miso;
   logic        cs_n;

   modport master (
      output start, datos_in, miso,
      input  busy, datos_rx, wr_rx, done, sclk, mosi, cs_n
   );

   modport slave (
      input  start, datos_in, miso,
      output busy, datos_rx, wr_rx, done, sclk, mosi, cs_n
   );
endinterface

// File: rtl/spi_datos_tx.sv
// SPI mode-0 frame transmitter/receiver: shifts BITS bits MSB-first on mosi while sampling miso,
// then hands the received word to the data register with a one-cycle wr_rx/done strobe.
module spi_datos_tx #(
   parameter int DIV  = 2,
   parameter int BITS = 12
) (
   input  logic          clk,
   input  logic          rst,
   spi_datos_tx_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEAD  = 3'd1,
      HIGH  = 3'd2,
      LOW   = 3'd3,
      TRAIL = 3'd4
   } state_t;

   localparam logic [7:0]  PHASE_LAST = 8'(DIV - 1);
   localparam logic [5:0]  BITS_CNT   = 6'(BITS);
   localparam logic [31:0] FRAME_MASK = (BITS >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << BITS) - 32'd1);

   // Every architectural register lives in one struct so reset and update are single statements.
   typedef struct packed {
      state_t      state;
      logic [7:0]  phase;
      logic [5:0]  bit_cnt;
      logic [31:0] tx_sr;
      logic [31:0] rx_sr;
      logic [31:0] datos_rx;
      logic        sclk;
      logic        mosi;
      logic        cs_n;
      logic        busy;
      logic        done;
      logic        wr_rx;
   } regs_t;

   regs_t r;
   regs_t nx;
   logic  phase_last;

   assign phase_last = (r.phase == PHASE_LAST);

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r       <= '0;
         r.state <= IDLE;
         r.cs_n  <= 1'b1;
      end else begin
         r <= nx;
      end
   end

   // NOTE: nx starts as a full copy of r, so every path assigns every field and no latch is inferred.
   always_comb begin
      nx       = r;
      nx.done  = 1'b0;
      nx.wr_rx = 1'b0;
      nx.phase = r.phase + 8'd1;

      case (r.state)
         IDLE: begin
            nx.phase = '0;
            if (bus.start) begin
               nx.state   = LEAD;
               nx.tx_sr   = bus.datos_in & FRAME_MASK;
               nx.rx_sr   = '0;
               nx.bit_cnt = '0;
               nx.cs_n    = 1'b0;
               nx.busy    = 1'b1;
               nx.mosi    = bus.datos_in[BITS-1];
            end
         end

         // Rising SCLK: slave data is captured on the same edge that raises the clock.
         LEAD, LOW: begin
            if (phase_last) begin
               nx.state   = HIGH;
               nx.phase   = '0;
               nx.sclk    = 1'b1;
               nx.rx_sr   = {r.rx_sr[30:0], bus.miso};
               nx.bit_cnt = r.bit_cnt + 6'd1;
            end
         end

         HIGH: begin
            if (phase_last) begin
               nx.phase = '0;
               nx.sclk  = 1'b0;
               if (r.bit_cnt == BITS_CNT) begin
                  nx.state = TRAIL;
               end else begin
                  nx.state = LOW;
                  nx.tx_sr = r.tx_sr << 1;
                  nx.mosi  = nx.tx_sr[BITS-1];
               end
            end
         end

         TRAIL: begin
            if (phase_last) begin
               nx.state    = IDLE;
               nx.phase    = '0;
               nx.cs_n     = 1'b1;
               nx.busy     = 1'b0;
               nx.mosi     = 1'b0;
               nx.datos_rx = r.rx_sr & FRAME_MASK;
               nx.done     = 1'b1;
               nx.wr_rx    = 1'b1;
            end
         end

         default: begin
            nx.state = IDLE;
            nx.phase = '0;
         end
      endcase
   end

   assign bus.sclk     = r.sclk;
   assign bus.mosi     = r.mosi;
   assign bus.cs_n     = r.cs_n;
   assign bus.busy     = r.busy;
   assign bus.done     = r.done;
   assign bus.wr_rx    = r.wr_rx;
   assign bus.datos_rx = r.datos_rx;

endmodule

// File: tb/tb_spi_datos_tx.sv
// Self-checking bench for spi_datos_tx: random frames compared against a frame-level model
// (expected bit order, frame length, SCLK count, received word) plus a DIV=1/BITS=1 corner instance.
module tb_spi_datos_tx;

   localparam int          DIV   = 2;
   localparam int          BITS  = 12;
   localparam int          FRAME = (2 * BITS + 1) * DIV;
   localparam logic [31:0] MASK  = (32'd1 << BITS) - 32'd1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;

   spi_datos_tx_if bus ();
   spi_datos_tx_if bus1 ();

   spi_datos_tx #(.DIV(DIV), .BITS(BITS)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   spi_datos_tx #(.DIV(1), .BITS(1)) u_min (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   always #5 clk = ~clk;

   // Observation state accumulated once per cycle by sample().
   bit          loop_mode;
   logic [31:0] rx_pat;
   int          rises, wr_cnt, done_cnt;
   int          coinc_err, busy_err, idle_err, hold_err, upper_err;
   int          low_run, high_run;
   bit          seen_frame;
   logic        prev_cs, prev_sclk;
   logic [31:0] prev_rx;
   int          lows[$];
   int          gaps[$];
   logic        mosi_bits[$];
   logic [31:0] rx_words[$];

   task automatic clear_obs();
      rises = 0; wr_cnt = 0; done_cnt = 0;
      coinc_err = 0; busy_err = 0; idle_err = 0; hold_err = 0; upper_err = 0;
      low_run = 0; high_run = 0; seen_frame = 0;
      prev_cs = bus.cs_n; prev_sclk = bus.sclk; prev_rx = bus.datos_rx;
      lows.delete(); gaps.delete(); mosi_bits.delete(); rx_words.delete();
   endtask

   task automatic sample();
      if (bus.cs_n === 1'b0) begin
         if (prev_cs === 1'b1 && seen_frame) gaps.push_back(high_run);
         low_run++;
      end else begin
         if (prev_cs === 1'b0) begin
            lows.push_back(low_run);
            low_run    = 0;
            high_run   = 0;
            seen_frame = 1;
         end
         high_run++;
         if (bus.mosi !== 1'b0 || bus.sclk !== 1'b0) idle_err++;
      end
      if (bus.sclk === 1'b1 && prev_sclk === 1'b0) begin
         rises++;
         mosi_bits.push_back(bus.mosi);
      end
      if (bus.wr_rx === 1'b1) begin
         wr_cnt++;
         rx_words.push_back(bus.datos_rx);
      end else if (bus.datos_rx !== prev_rx) begin
         hold_err++;
      end
      if (bus.done === 1'b1) done_cnt++;
      if (bus.done !== bus.wr_rx) coinc_err++;
      if (bus.busy !== ~bus.cs_n) busy_err++;
      if ((bus.datos_rx & ~MASK) !== 32'd0) upper_err++;
      prev_cs   = bus.cs_n;
      prev_sclk = bus.sclk;
      prev_rx   = bus.datos_rx;
   endtask

   // Drive inputs just after a falling edge, let one rising edge pass, observe on the next falling edge.
   task automatic step(input logic st);
      bus.start = st;
      bus.miso  = loop_mode ? bus.mosi : rx_pat[BITS - 1 - (rises % BITS)];
      @(posedge clk);
      @(negedge clk);
      sample();
   endtask

   // Reassemble frame f's transmitted bits (as seen at each SCLK rise) into a word, MSB first.
   function automatic logic [31:0] mosi_word(input int f);
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < BITS; i++)
         if (f * BITS + i < mosi_bits.size()) w = {w[30:0], mosi_bits[f * BITS + i]};
      return w;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b1; bus.datos_in = 32'hFFFF_FFFF; bus.miso = 1'b1;
      bus1.start = 1'b1; bus1.datos_in = 32'h1; bus1.miso = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({bus.cs_n, bus.sclk, bus.mosi, bus.busy, bus.done, bus.wr_rx} !== 6'b100000) begin
         n_bad++;
         $display("FAIL reset_pins {cs_n,sclk,mosi,busy,done,wr_rx}: got %b want 100000",
                  {bus.cs_n, bus.sclk, bus.mosi, bus.busy, bus.done, bus.wr_rx});
      end
      n_cmp++;
      if (bus.datos_rx !== 32'd0) begin
         n_bad++; $display("FAIL reset_datos_rx: got %h want 0", bus.datos_rx);
      end
      n_cmp++;
      if ({bus1.cs_n, bus1.busy} !== 2'b10) begin
         n_bad++; $display("FAIL reset_min {cs_n,busy}: got %b want 10", {bus1.cs_n, bus1.busy});
      end
      rst = 1'b0; bus.start = 1'b0; bus1.start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.cs_n !== 1'b1) begin
         n_bad++; $display("FAIL idle_after_reset cs_n: got %b want 1", bus.cs_n);
      end
   endtask

   task automatic test_loopback();
      logic [31:0] d;
      loop_mode = 1;
      for (int k = 0; k < 5; k++) begin
         d = (k == 0) ? 32'h0000_0A5C : $urandom();
         bus.datos_in = d;
         clear_obs();
         step(1'b1);
         repeat (FRAME + 8) step(1'b0);
         n_cmp++;
         if (lows.size() !== 1 || lows[0] !== FRAME) begin
            n_bad++; $display("FAIL loop%0d cs_n_low: frames %0d len %0d want 1 x %0d",
                              k, lows.size(), (lows.size() > 0) ? lows[0] : -1, FRAME);
         end
         n_cmp++;
         if (rises !== BITS) begin
            n_bad++; $display("FAIL loop%0d sclk_rises: got %0d want %0d", k, rises, BITS);
         end
         n_cmp++;
         if (mosi_word(0) !== (d & MASK)) begin
            n_bad++; $display("FAIL loop%0d mosi_bits: got %h want %h", k, mosi_word(0), d & MASK);
         end
         n_cmp++;
         if (wr_cnt !== 1 || done_cnt !== 1 || rx_words.size() !== 1 || rx_words[0] !== (d & MASK)) begin
            n_bad++; $display("FAIL loop%0d datos_rx: wr %0d done %0d word %h want 1/1/%h", k, wr_cnt,
                              done_cnt, (rx_words.size() > 0) ? rx_words[0] : 32'hX, d & MASK);
         end
         n_cmp++;
         if (coinc_err + busy_err + idle_err + hold_err + upper_err !== 0) begin
            n_bad++; $display("FAIL loop%0d protocol: coinc %0d busy %0d idle %0d hold %0d upper %0d want 0",
                              k, coinc_err, busy_err, idle_err, hold_err, upper_err);
         end
      end
   endtask

   task automatic test_miso_pattern();
      logic [31:0] d;
      loop_mode = 0;
      for (int k = 0; k < 4; k++) begin
         d      = (k == 0) ? 32'hFFFF_F000 : $urandom();
         rx_pat = (k == 0) ? 32'hFFFF_FFFF : $urandom();
         bus.datos_in = d;
         clear_obs();
         step(1'b1);
         repeat (FRAME + 8) step(1'b0);
         n_cmp++;
         if (mosi_word(0) !== (d & MASK) || rises !== BITS) begin
            n_bad++; $display("FAIL miso%0d mosi_bits: got %h (%0d rises) want %h (%0d rises)",
                              k, mosi_word(0), rises, d & MASK, BITS);
         end
         n_cmp++;
         if (wr_cnt !== 1 || rx_words.size() !== 1 || rx_words[0] !== (rx_pat & MASK)) begin
            n_bad++; $display("FAIL miso%0d datos_rx: wr %0d word %h want 1/%h", k, wr_cnt,
                              (rx_words.size() > 0) ? rx_words[0] : 32'hX, rx_pat & MASK);
         end
         n_cmp++;
         if (coinc_err + busy_err + idle_err + hold_err + upper_err !== 0) begin
            n_bad++; $display("FAIL miso%0d protocol: errors %0d want 0",
                              k, coinc_err + busy_err + idle_err + hold_err + upper_err);
         end
      end
   endtask

   task automatic test_ignored_start();
      logic [31:0] d;
      loop_mode = 1;
      d = $urandom();
      bus.datos_in = d;
      clear_obs();
      step(1'b1);
      for (int i = 1; i < FRAME + 8; i++) begin
         if (i == 10) bus.datos_in = ~d;
         step(i == 5 || i == 30);
      end
      n_cmp++;
      if (lows.size() !== 1 || wr_cnt !== 1) begin
         n_bad++; $display("FAIL ignored_start frames: got %0d frames %0d wr_rx want 1/1", lows.size(), wr_cnt);
      end
      n_cmp++;
      if (mosi_word(0) !== (d & MASK)) begin
         n_bad++; $display("FAIL ignored_start mosi_bits: got %h want %h", mosi_word(0), d & MASK);
      end
      n_cmp++;
      if (rx_words.size() !== 1 || rx_words[0] !== (d & MASK)) begin
         n_bad++; $display("FAIL ignored_start datos_rx: got %h want %h",
                           (rx_words.size() > 0) ? rx_words[0] : 32'hX, d & MASK);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      int          bad_len, bad_gap, bad_rx, bad_tx;
      loop_mode = 0;
      d      = $urandom();
      rx_pat = $urandom() | 32'h1;
      bus.datos_in = d;
      clear_obs();
      for (int i = 0; i < 170; i++) step(i < 110);
      bad_len = 0; bad_gap = 0; bad_rx = 0; bad_tx = 0;
      foreach (lows[i]) if (lows[i] !== FRAME) bad_len++;
      foreach (gaps[i]) if (gaps[i] !== 1) bad_gap++;
      foreach (rx_words[i]) if (rx_words[i] !== (rx_pat & MASK)) bad_rx++;
      for (int f = 0; f < 3; f++) if (mosi_word(f) !== (d & MASK)) bad_tx++;
      n_cmp++;
      if (lows.size() !== 3 || bad_len !== 0) begin
         n_bad++; $display("FAIL b2b frames: got %0d frames, %0d wrong length, want 3 x %0d", lows.size(), bad_len, FRAME);
      end
      n_cmp++;
      if (gaps.size() !== 2 || bad_gap !== 0) begin
         n_bad++; $display("FAIL b2b cs_n_gap: got %0d gaps, %0d not 1 cycle, want 2/0", gaps.size(), bad_gap);
      end
      n_cmp++;
      if (wr_cnt !== 3 || bad_rx !== 0 || rises !== 3 * BITS || bad_tx !== 0) begin
         n_bad++; $display("FAIL b2b data: wr %0d bad_rx %0d rises %0d bad_tx %0d want 3/0/%0d/0",
                           wr_cnt, bad_rx, rises, bad_tx, 3 * BITS);
      end
      n_cmp++;
      if (coinc_err + busy_err + hold_err + upper_err !== 0) begin
         n_bad++; $display("FAIL b2b protocol: errors %0d want 0", coinc_err + busy_err + hold_err + upper_err);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] d;
      loop_mode = 1;
      d = $urandom() | 32'h1;
      bus.datos_in = d;
      clear_obs();
      step(1'b1);
      repeat (19) step(1'b0);
      rst = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({bus.cs_n, bus.sclk, bus.busy, bus.wr_rx, bus.done, bus.mosi} !== 6'b100000) begin
         n_bad++; $display("FAIL mid_reset {cs_n,sclk,busy,wr_rx,done,mosi}: got %b want 100000",
                           {bus.cs_n, bus.sclk, bus.busy, bus.wr_rx, bus.done, bus.mosi});
      end
      n_cmp++;
      if (bus.datos_rx !== 32'd0) begin
         n_bad++; $display("FAIL mid_reset datos_rx: got %h want 0", bus.datos_rx);
      end
      rst = 1'b0;
      bus.start = 1'b0;
      clear_obs();
      repeat (FRAME) step(1'b0);
      n_cmp++;
      if (wr_cnt !== 0 || done_cnt !== 0 || lows.size() !== 0 || low_run !== 0) begin
         n_bad++; $display("FAIL mid_reset aborted: wr %0d done %0d low_cycles %0d want 0/0/0",
                           wr_cnt, done_cnt, low_run);
      end
      clear_obs();
      step(1'b1);
      repeat (FRAME + 8) step(1'b0);
      n_cmp++;
      if (lows.size() !== 1 || lows[0] !== FRAME || wr_cnt !== 1 || rx_words[0] !== (d & MASK)) begin
         n_bad++; $display("FAIL mid_reset fresh_frame: frames %0d wr %0d word %h want 1/1/%h",
                           lows.size(), wr_cnt, (rx_words.size() > 0) ? rx_words[0] : 32'hX, d & MASK);
      end
   endtask

   task automatic test_minimal();
      int          low, mbad, rs, wr;
      logic        prev_s;
      logic [31:0] rx;
      for (int m = 0; m < 2; m++) begin
         low = 0; mbad = 0; rs = 0; wr = 0; prev_s = 1'b0; rx = 32'hDEAD_BEEF;
         bus1.datos_in = (m == 0) ? 32'h1 : ($urandom() | 32'h1);
         bus1.miso     = (m != 0);
         bus1.start    = 1'b1;
         for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus1.start = 1'b0;
            if (bus1.cs_n === 1'b0) begin
               low++;
               if (bus1.mosi !== 1'b1) mbad++;
            end
            if (bus1.sclk === 1'b1 && prev_s === 1'b0) rs++;
            prev_s = bus1.sclk;
            if (bus1.wr_rx === 1'b1) begin
               wr++;
               rx = bus1.datos_rx;
            end
         end
         n_cmp++;
         if (low !== 3 || mbad !== 0 || rs !== 1) begin
            n_bad++; $display("FAIL min%0d frame: cs_n_low %0d mosi_bad %0d rises %0d want 3/0/1", m, low, mbad, rs);
         end
         n_cmp++;
         if (wr !== 1 || rx !== {31'd0, (m != 0)}) begin
            n_bad++; $display("FAIL min%0d datos_rx: wr %0d word %h want 1/%h", m, wr, rx, {31'd0, (m != 0)});
         end
      end
   endtask

   initial begin
      loop_mode = 0;
      rx_pat    = '0;
      test_reset();
      test_loopback();
      test_miso_pattern();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid_frame();
      test_minimal();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
